// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame receiver: FSM encoding, default sync
// marker and timeout counter sizing.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    HOLD    = 2'd3
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Counter must reach cycles-1, so clog2(cycles) bits always suffice.
  function automatic int tmo_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_edge.sv
// Turns a level-style rx_done/rx_valid into a single-cycle accept strobe on
// its rising edge, so a byte held for many cycles is consumed once.
module uart_byte_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_valid,
  output logic accept
);

  logic rx_valid_q;

  always_ff @(posedge clk) begin
    if (!reset_n) rx_valid_q <= 1'b0;
    else          rx_valid_q <= rx_valid;
  end

  assign accept = rx_valid & ~rx_valid_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler: SYNC, payload bytes (MSB byte first), XOR checksum; holds
// the payload on a valid/ready handshake and pulses checksum/timeout/overrun errors.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = 2,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_valid,
  output logic [8*PAYLOAD_BYTES-1:0] frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       chk_err,
  output logic                       tmo_err,
  output logic                       ovr_err
);

  localparam int TW = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  frame_state_e state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [7:0] xacc, xacc_nx;
  logic [0:PAYLOAD_BYTES-1][7:0] pbuf, pbuf_nx;
  logic [8*PAYLOAD_BYTES-1:0] data_q, data_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic chk_nx, tmo_nx, ovr_nx, start, acc;

  uart_byte_edge u_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_valid (rx_valid),
    .accept   (acc)
  );

  assign frame_data  = data_q;
  assign frame_valid = (state == HOLD);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    xacc_nx  = xacc;
    pbuf_nx  = pbuf;
    data_nx  = data_q;
    cnt_nx   = cnt;
    chk_nx   = 1'b0;
    tmo_nx   = 1'b0;
    ovr_nx   = 1'b0;
    start    = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      idx_nx   = '0;
      xacc_nx  = '0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: start = acc && (rx_byte == SYNC_BYTE);
        PAYLOAD: if (acc) begin
          pbuf_nx[idx] = rx_byte;
          xacc_nx      = xacc ^ rx_byte;
          cnt_nx       = '0;
          if (idx == IW'(PAYLOAD_BYTES-1)) state_nx = CHECK;
          else                             idx_nx   = idx + IW'(1);
        end
        CHECK: if (acc) begin
          cnt_nx = '0;
          if (rx_byte == xacc) begin
            state_nx = HOLD;
            data_nx  = pbuf;
          end else begin
            chk_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
        HOLD: begin
          // A byte coinciding with the handshake is treated as the next frame's first byte.
          if (frame_ready) begin
            state_nx = IDLE;
            start    = acc && (rx_byte == SYNC_BYTE);
          end else if (acc) begin
            ovr_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
      if ((state == PAYLOAD || state == CHECK) && !acc) begin
        if (cnt == TW'(TIMEOUT_CYCLES-1)) begin
          tmo_nx   = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + TW'(1);
        end
      end
      if (start) begin
        state_nx = PAYLOAD;
        idx_nx   = '0;
        xacc_nx  = '0;
        cnt_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      xacc    <= '0;
      pbuf    <= '0;
      data_q  <= '0;
      cnt     <= '0;
      chk_err <= 1'b0;
      tmo_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      xacc    <= xacc_nx;
      pbuf    <= pbuf_nx;
      data_q  <= data_nx;
      cnt     <= cnt_nx;
      chk_err <= chk_nx;
      tmo_err <= tmo_nx;
      ovr_err <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed plus randomized bench for uart_frame_rx against a byte-queue reference model.
module tb_uart_frame_rx;

  localparam int         PB   = 2;
  localparam int         T    = 50;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, rx_valid = 1'b0, frame_ready = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [8*PB-1:0] frame_data;
  logic frame_valid, chk_err, tmo_err, ovr_err;

  uart_frame_rx #(.PAYLOAD_BYTES(PB), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .chk_err(chk_err), .tmo_err(tmo_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int n_chk = 0, n_tmo = 0, n_ovr = 0, tmo_cyc = -1, acc_cyc = 0;
  bit rnd_ready = 0;

  // Reference model: collected bytes in a queue, pending frame, idle cycle count.
  bit m_prev = 0, m_infr = 0, m_hold = 0, m_chk = 0, m_tmo = 0, m_ovr = 0;
  logic [7:0] m_q[$];
  logic [8*PB-1:0] m_data = '0;
  int m_cnt = 0;

  task automatic model_cycle();
    bit acc, idle_byte;
    logic [7:0] x;
    acc = rx_valid && !m_prev;
    m_chk = 0; m_tmo = 0; m_ovr = 0;
    if (!reset_n) begin
      m_prev = 0; m_infr = 0; m_hold = 0; m_q.delete(); m_cnt = 0; m_data = '0;
      return;
    end
    m_prev = rx_valid;
    if (!enable) begin
      m_infr = 0; m_hold = 0; m_q.delete(); m_cnt = 0;
      return;
    end
    idle_byte = 0;
    if (m_hold) begin
      if (frame_ready) begin m_hold = 0; idle_byte = acc; end
      else if (acc) m_ovr = 1;
    end else if (m_infr) begin
      if (acc) begin
        m_cnt = 0;
        if (m_q.size() < PB) m_q.push_back(rx_byte);
        else begin
          x = 8'h00;
          foreach (m_q[i]) x ^= m_q[i];
          if (x == rx_byte) begin
            m_hold = 1;
            m_data = '0;
            foreach (m_q[i]) m_data = (m_data << 8) | (8*PB)'(m_q[i]);
          end else m_chk = 1;
          m_infr = 0;
        end
      end else if (m_cnt == T-1) begin
        m_tmo = 1; m_infr = 0; m_cnt = 0;
      end else m_cnt++;
    end else idle_byte = acc;
    if (idle_byte && rx_byte == SYNC) begin
      m_infr = 1; m_q.delete(); m_cnt = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (rnd_ready) frame_ready = ($urandom_range(0, 2) == 0);
    model_cycle();
    @(posedge clk); #1;
    cyc++;
    if (chk_err) n_chk++;
    if (ovr_err) n_ovr++;
    if (tmo_err) begin n_tmo++; tmo_cyc = cyc; end
    chk("frame_valid", 64'(frame_valid), 64'(m_hold));
    chk("frame_data", 64'(frame_data), 64'(m_data));
    chk("chk_err", 64'(chk_err), 64'(m_chk));
    chk("tmo_err", 64'(tmo_err), 64'(m_tmo));
    chk("ovr_err", 64'(ovr_err), 64'(m_ovr));
  endtask

  task automatic send(input logic [7:0] b, input int h, input int g);
    rx_byte = b; rx_valid = 1'b1;
    step();
    acc_cyc = cyc;
    repeat (h-1) step();
    rx_valid = 1'b0;
    repeat (g) step();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int h);
    send(SYNC, h, 2); send(a, h, 2); send(b, h, 2); send(c, h, 2);
  endtask

  task automatic release_frame();
    frame_ready = 1'b1; step(); frame_ready = 1'b0;
    chk("release", 64'(frame_valid), 64'd0);
  endtask

  initial begin
    int base, b_t;
    logic [7:0] p0, p1, ck;

    repeat (3) step();
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_data", 64'(frame_data), 64'd0);
    chk("rst_errs", 64'({chk_err, tmo_err, ovr_err}), 64'd0);
    reset_n = 1'b1; enable = 1'b1; step();

    // Nominal frame, long rx_valid levels, delayed ready
    send(SYNC, 20, 2); send(8'h12, 20, 2); send(8'h34, 20, 2);
    rx_byte = 8'h26; rx_valid = 1'b1; step();
    chk("nom_latency", 64'(frame_valid), 64'd1);
    chk("nom_data", 64'(frame_data), 64'h1234);
    repeat (19) step(); rx_valid = 1'b0; step();
    repeat (5) step();
    chk("nom_held", 64'(frame_valid), 64'd1);
    release_frame();
    chk("nom_no_err", 64'(n_chk + n_tmo + n_ovr), 64'd0);

    // Bad checksum then good frame
    base = n_chk;
    send_frame(8'h12, 8'h34, 8'h00, 3);
    chk("bad_chk_pulse", 64'(n_chk - base), 64'd1);
    chk("bad_no_valid", 64'(frame_valid), 64'd0);
    send_frame(8'hAB, 8'hCD, 8'h66, 3);
    chk("good_after_bad", 64'(frame_data), 64'hABCD);
    release_frame();

    // Garbage ignored, then timeout
    send(8'h00, 2, 1); send(8'hFF, 2, 1); send(8'h5A, 2, 1);
    chk("garbage_idle", 64'(frame_valid), 64'd0);
    b_t = n_tmo;
    send(SYNC, 2, 1); send(8'h12, 2, 1);
    repeat (60) step();
    chk("tmo_count", 64'(n_tmo - b_t), 64'd1);
    chk("tmo_delay", 64'(tmo_cyc - acc_cyc), 64'd50);
    send(SYNC, 2, 1); send(8'h01, 2, 1); send(8'h02, 2, 1); send(8'h03, 2, 1);
    chk("after_tmo", 64'(frame_data), 64'h0102);
    chk("after_tmo_v", 64'(frame_valid), 64'd1);
    release_frame();

    // Overrun, then sync coincident with ready
    send_frame(8'h12, 8'h34, 8'h26, 2);
    base = n_ovr;
    send(8'h77, 2, 1);
    chk("ovr_pulse", 64'(n_ovr - base), 64'd1);
    chk("ovr_data", 64'(frame_data), 64'h1234);
    rx_byte = SYNC; rx_valid = 1'b1; frame_ready = 1'b1; step();
    frame_ready = 1'b0;
    chk("sync_on_ready", 64'(frame_valid), 64'd0);
    step(); rx_valid = 1'b0; step();
    send(8'h55, 2, 1); send(8'h66, 2, 1); send(8'h33, 2, 1);
    chk("chained_frame", 64'(frame_data), 64'h5566);
    release_frame();

    // Reset mid-frame
    base = n_chk + n_tmo + n_ovr;
    send(SYNC, 2, 1); send(8'h12, 2, 1);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    send(8'h34, 2, 1); send(8'h26, 2, 1);
    chk("rst_mid_valid", 64'(frame_valid), 64'd0);
    chk("rst_mid_errs", 64'(n_chk + n_tmo + n_ovr - base), 64'd0);

    // Enable low mid-frame, and a byte held across enable rising
    send(SYNC, 2, 1); send(8'h12, 2, 1);
    enable = 1'b0; repeat (3) step(); enable = 1'b1;
    send_frame(8'h12, 8'h34, 8'h26, 2);
    chk("en_frame", 64'(frame_data), 64'h1234);
    release_frame();
    rx_byte = SYNC; rx_valid = 1'b1; enable = 1'b0; step(); enable = 1'b1;
    repeat (3) step(); rx_valid = 1'b0; step();
    send(8'h9A, 2, 1); send(8'hBC, 2, 1); send(8'h26, 2, 1);
    chk("en_no_reaccept", 64'(frame_valid), 64'd0);

    // Randomized traffic
    rnd_ready = 1;
    for (int it = 0; it < 80; it++) begin
      p0 = 8'($urandom); p1 = 8'($urandom); ck = p0 ^ p1;
      case ($urandom_range(0, 6))
        0, 1: begin
          send(SYNC, $urandom_range(1, 5), $urandom_range(1, 3));
          send(p0, $urandom_range(1, 5), $urandom_range(1, 3));
          send(p1, $urandom_range(1, 5), $urandom_range(1, 3));
          send(ck, $urandom_range(1, 5), $urandom_range(1, 3));
        end
        2: begin
          send(SYNC, 2, 1); send(p0, 2, 1); send(p1, 2, 1);
          send(ck ^ 8'($urandom_range(1, 255)), 2, 1);
        end
        3: send(8'($urandom), $urandom_range(1, 5), $urandom_range(1, 3));
        4: begin
          send(SYNC, 1, 1);
          if ($urandom_range(0, 1) == 1) send(p0, 1, 1);
          repeat ($urandom_range(40, 60)) step();
        end
        5: begin
          enable = 1'b0; repeat ($urandom_range(1, 3)) step(); enable = 1'b1;
        end
        default: begin
          send(SYNC, 1, 1); send(p0, 1, 1);
          reset_n = 1'b0; step(); reset_n = 1'b1;
        end
      endcase
    end
    rnd_ready = 0; frame_ready = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
